// File: rtl/nf10_sram_fifo_ingress.sv
// Ingress stage ahead of the SRAM packet FIFO: two-entry skid buffer, whole-packet
// discard selected at the first beat, and passed/dropped/byte statistics.
module nf10_sram_fifo_ingress #(
  parameter int C_DATA_WIDTH  = 256,
  parameter int C_TUSER_WIDTH = 128,
  parameter int C_CNT_WIDTH   = 32
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [C_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_TUSER_WIDTH-1:0]    s_axis_tuser,
  input  logic [C_DATA_WIDTH/8-1:0]   s_axis_tstrb,
  input  logic                        s_axis_tlast,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [C_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_TUSER_WIDTH-1:0]    m_axis_tuser,
  output logic [C_DATA_WIDTH/8-1:0]   m_axis_tstrb,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  input  logic                        drop_en,
  input  logic                        clear_stats,
  output logic [C_CNT_WIDTH-1:0]      pkt_cnt,
  output logic [C_CNT_WIDTH-1:0]      drop_cnt,
  output logic [C_CNT_WIDTH-1:0]      byte_cnt,
  output logic                        in_pkt
);

  localparam int STRB_W = C_DATA_WIDTH / 8;
  localparam int BEAT_W = C_DATA_WIDTH + C_TUSER_WIDTH + STRB_W + 1;
  localparam int POP_W  = $clog2(STRB_W + 1);

  typedef enum logic [1:0] {ST_SOP, ST_PASS, ST_DROP} state_t;

  state_t                 state_q, state_d;
  logic [BEAT_W-1:0]      mem_q [2];
  logic [BEAT_W-1:0]      mem_d [2];
  logic                   rd_ptr_q, rd_ptr_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic [1:0]             occ_q, occ_d;
  logic                   not_full_q, not_full_d;
  logic                   alive_q;
  logic [C_CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [C_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic [C_CNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;

  logic                   drop_mode;
  logic                   s_acc;
  logic                   wr_en;
  logic                   disc_en;
  logic                   rd_en;
  logic [POP_W-1:0]       strb_pop;
  logic [BEAT_W-1:0]      s_beat;

  // A packet being discarded never back-pressures; alive_q keeps tready low in reset.
  assign drop_mode     = (state_q == ST_DROP) || ((state_q == ST_SOP) && drop_en);
  assign s_axis_tready = alive_q & (drop_mode | not_full_q);

  assign s_acc   = s_axis_tvalid & s_axis_tready;
  assign wr_en   = s_acc & ((state_q == ST_PASS) || ((state_q == ST_SOP) && !drop_en));
  assign disc_en = s_acc & !wr_en;
  assign rd_en   = m_axis_tvalid & m_axis_tready;
  assign s_beat  = {s_axis_tdata, s_axis_tuser, s_axis_tstrb, s_axis_tlast};

  assign {m_axis_tdata, m_axis_tuser, m_axis_tstrb, m_axis_tlast} = mem_q[rd_ptr_q];
  assign m_axis_tvalid = (occ_q != 2'd0);

  assign in_pkt   = (state_q != ST_SOP);
  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
  assign byte_cnt = byte_cnt_q;

  always_comb begin
    strb_pop = '0;
    for (int i = 0; i < STRB_W; i++) begin
      strb_pop = strb_pop + POP_W'(s_axis_tstrb[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    if (s_acc) begin
      case (state_q)
        ST_SOP:  if (!s_axis_tlast) state_d = drop_en ? ST_DROP : ST_PASS;
        ST_PASS: if (s_axis_tlast) state_d = ST_SOP;
        ST_DROP: if (s_axis_tlast) state_d = ST_SOP;
        default: state_d = ST_SOP;
      endcase
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = s_beat;
    wr_ptr_d = wr_ptr_q ^ wr_en;
    rd_ptr_d = rd_ptr_q ^ rd_en;
    case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
    not_full_d = (occ_d != 2'd2);
  end

  // Clear wins over any increment landing on the same edge.
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    byte_cnt_d = byte_cnt_q;
    if (wr_en) begin
      byte_cnt_d = byte_cnt_q + C_CNT_WIDTH'(strb_pop);
      if (s_axis_tlast) pkt_cnt_d = pkt_cnt_q + C_CNT_WIDTH'(1);
    end
    if (disc_en && s_axis_tlast) drop_cnt_d = drop_cnt_q + C_CNT_WIDTH'(1);
    if (clear_stats) begin
      pkt_cnt_d  = '0;
      drop_cnt_d = '0;
      byte_cnt_d = '0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= ST_SOP;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      not_full_q <= 1'b0;
      alive_q    <= 1'b0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      not_full_q <= not_full_d;
      alive_q    <= 1'b1;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

endmodule

// File: tb/tb_nf10_sram_fifo_ingress.sv
// Scenario bench for nf10_sram_fifo_ingress: a negedge monitor keeps a beat scoreboard
// and reference counters; scenario tasks add targeted end-of-scenario checks.
module tb_nf10_sram_fifo_ingress;

  localparam int BW = 256 + 128 + 32 + 1;
  typedef logic [BW-1:0] beat_t;

  logic         clk = 1'b0;
  logic         areset = 1'b1;
  logic [255:0] s_axis_tdata = '0;
  logic [127:0] s_axis_tuser = '0;
  logic [31:0]  s_axis_tstrb = '0;
  logic         s_axis_tlast = 1'b0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic [255:0] m_axis_tdata;
  logic [127:0] m_axis_tuser;
  logic [31:0]  m_axis_tstrb;
  logic         m_axis_tlast;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b1;
  logic         drop_en = 1'b0;
  logic         clear_stats = 1'b0;
  logic [31:0]  pkt_cnt, drop_cnt, byte_cnt;
  logic         in_pkt;

  logic         sm_tready, sm_tlast, sm_tvalid, sm_in_pkt;
  logic [255:0] sm_tdata;
  logic [127:0] sm_tuser;
  logic [31:0]  sm_tstrb;
  logic [7:0]   sm_pkt_cnt, sm_drop_cnt, sm_byte_cnt;

  int checks = 0;
  int errors = 0;
  int n_out = 0;
  bit mon_en = 1'b0;
  bit tog_done = 1'b0;
  int rel_edges = 0;

  beat_t       sb[$];
  int          st = 0;
  logic [31:0] e_pkt = '0, e_drop = '0, e_byte = '0;

  always #5 clk = ~clk;

  nf10_sram_fifo_ingress dut (
    .aclk(clk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tstrb(s_axis_tstrb),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tstrb(m_axis_tstrb),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .drop_en(drop_en), .clear_stats(clear_stats),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .byte_cnt(byte_cnt), .in_pkt(in_pkt)
  );

  // Narrow-counter twin sharing all stimulus, used to observe counter wrap.
  nf10_sram_fifo_ingress #(.C_CNT_WIDTH(8)) dut_small (
    .aclk(clk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tstrb(s_axis_tstrb),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(sm_tready),
    .m_axis_tdata(sm_tdata), .m_axis_tuser(sm_tuser), .m_axis_tstrb(sm_tstrb),
    .m_axis_tlast(sm_tlast), .m_axis_tvalid(sm_tvalid), .m_axis_tready(m_axis_tready),
    .drop_en(drop_en), .clear_stats(clear_stats),
    .pkt_cnt(sm_pkt_cnt), .drop_cnt(sm_drop_cnt), .byte_cnt(sm_byte_cnt), .in_pkt(sm_in_pkt)
  );

  always @(posedge clk or posedge areset) begin
    if (areset) rel_edges <= 0;
    else if (rel_edges < 2) rel_edges <= rel_edges + 1;
  end

  // Monitor: everything sampled at negedge describes the upcoming rising edge.
  always @(negedge clk) begin
    int occ;
    logic exp_rdy;
    logic pass;
    if (areset) begin
      sb.delete();
      st = 0;
      e_pkt = '0; e_drop = '0; e_byte = '0;
    end else if (mon_en) begin
      occ = sb.size();
      checks++;
      if (m_axis_tvalid !== (occ != 0)) begin
        errors++;
        $display("FAIL m_tvalid: got %0b, required %0b (occupancy %0d)", m_axis_tvalid, occ != 0, occ);
      end
      if (occ != 0) begin
        checks++;
        if ({m_axis_tdata, m_axis_tuser, m_axis_tstrb, m_axis_tlast} !== sb[0]) begin
          errors++;
          $display("FAIL m_beat: got data=%h.. strb=%h last=%0b, required data=%h.. strb=%h last=%0b",
                   m_axis_tdata[255:224], m_axis_tstrb, m_axis_tlast,
                   sb[0][BW-1 -: 32], sb[0][32:1], sb[0][0]);
        end
      end
      exp_rdy = (rel_edges == 0) ? 1'b0 : ((st == 2) || (st == 0 && drop_en) || (occ < 2));
      checks++;
      if (s_axis_tready !== exp_rdy) begin
        errors++;
        $display("FAIL s_tready: got %0b, required %0b (state %0d occupancy %0d)", s_axis_tready, exp_rdy, st, occ);
      end
      checks++;
      if (pkt_cnt !== e_pkt || drop_cnt !== e_drop || byte_cnt !== e_byte || sm_byte_cnt !== e_byte[7:0]) begin
        errors++;
        $display("FAIL counters: got pkt=%0d drop=%0d byte=%0d small_byte=%0d, required pkt=%0d drop=%0d byte=%0d small_byte=%0d",
                 pkt_cnt, drop_cnt, byte_cnt, sm_byte_cnt, e_pkt, e_drop, e_byte, e_byte[7:0]);
      end
      checks++;
      if (in_pkt !== (st != 0)) begin
        errors++;
        $display("FAIL in_pkt: got %0b, required %0b", in_pkt, st != 0);
      end
      if (m_axis_tvalid && m_axis_tready && occ != 0) begin
        void'(sb.pop_front());
        n_out++;
      end
      if (s_axis_tvalid && s_axis_tready) begin
        pass = (st == 1) || (st == 0 && !drop_en);
        if (pass) begin
          sb.push_back({s_axis_tdata, s_axis_tuser, s_axis_tstrb, s_axis_tlast});
          e_byte = e_byte + 32'($countones(s_axis_tstrb));
          if (s_axis_tlast) e_pkt = e_pkt + 1;
        end else if (s_axis_tlast) begin
          e_drop = e_drop + 1;
        end
        if (st == 0) st = s_axis_tlast ? 0 : (drop_en ? 2 : 1);
        else if (s_axis_tlast) st = 0;
      end
      if (clear_stats) begin
        e_pkt = '0; e_drop = '0; e_byte = '0;
      end
    end
  end

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive_beat(input logic [255:0] d, input logic [31:0] strb, input logic last, output int waits);
    s_axis_tdata  = d;
    s_axis_tuser  = d[255:128] ^ d[127:0];
    s_axis_tstrb  = strb;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!s_axis_tready && waits < 200);
    checks++;
    if (!s_axis_tready) begin
      errors++;
      $display("FAIL accept_timeout: s_tready=%0b after %0d cycles, required 1", s_axis_tready, waits);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear_stats = 1'b1;
    settle(1);
    clear_stats = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    settle(3);
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tlast !== 1'b0 ||
        pkt_cnt !== '0 || drop_cnt !== '0 || byte_cnt !== '0 || in_pkt !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got tready=%0b tvalid=%0b pkt=%0d drop=%0d byte=%0d in_pkt=%0b, required all 0",
               s_axis_tready, m_axis_tvalid, pkt_cnt, drop_cnt, byte_cnt, in_pkt);
    end
    @(posedge clk); #2;
    areset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got %0b, required 0", s_axis_tready);
    end
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_edge: got %0b, required 1", s_axis_tready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_pass();
    int w, n0;
    n0 = n_out;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) drive_beat(rand256(), (i == 3) ? 32'h0000_FFFF : 32'hFFFF_FFFF, i == 3, w);
    idle();
    settle(3);
    @(negedge clk);
    checks++;
    if (n_out - n0 !== 4 || pkt_cnt !== 32'd1 || byte_cnt !== 32'd112 || drop_cnt !== 32'd0) begin
      errors++;
      $display("FAIL pass_pkt: got beats=%0d pkt=%0d byte=%0d drop=%0d, required beats=4 pkt=1 byte=112 drop=0",
               n_out - n0, pkt_cnt, byte_cnt, drop_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_drop();
    int w;
    pulse_clear();
    m_axis_tready = 1'b0;
    drop_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_beat(rand256(), 32'hFFFF_FFFF, i == 2, w);
      drop_en = 1'b0;
      checks++;
      if (w !== 1) begin
        errors++;
        $display("FAIL drop_ready: beat %0d waited %0d cycles, required 1", i, w);
      end
    end
    idle();
    @(negedge clk);
    checks++;
    if (m_axis_tvalid !== 1'b0 || drop_cnt !== 32'd1 || pkt_cnt !== 32'd0) begin
      errors++;
      $display("FAIL drop_pkt: got tvalid=%0b drop=%0d pkt=%0d, required tvalid=0 drop=1 pkt=0",
               m_axis_tvalid, drop_cnt, pkt_cnt);
    end
    @(posedge clk); #1;
    m_axis_tready = 1'b1;
  endtask

  task automatic test_drop_mid();
    int w, n0;
    pulse_clear();
    n0 = n_out;
    for (int i = 0; i < 3; i++) begin
      drop_en = (i != 0);
      drive_beat(rand256(), $urandom, i == 2, w);
    end
    drop_en = 1'b0;
    idle();
    settle(3);
    @(negedge clk);
    checks++;
    if (n_out - n0 !== 3 || pkt_cnt !== 32'd1 || drop_cnt !== 32'd0) begin
      errors++;
      $display("FAIL drop_mid: got beats=%0d pkt=%0d drop=%0d, required beats=3 pkt=1 drop=0",
               n_out - n0, pkt_cnt, drop_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = n_out;
    tog_done = 1'b0;
    fork
      begin
        while (!tog_done) begin
          @(posedge clk); #1;
          m_axis_tready = ~m_axis_tready;
        end
      end
      begin
        int w;
        for (int i = 0; i < 12; i++) drive_beat(rand256(), (i == 5) ? 32'h0 : $urandom, i == 11, w);
        idle();
        tog_done = 1'b1;
      end
    join
    m_axis_tready = 1'b1;
    settle(4);
    @(negedge clk);
    checks++;
    if (n_out - n0 !== 12 || sb.size() != 0) begin
      errors++;
      $display("FAIL back_to_back: got beats=%0d left=%0d, required beats=12 left=0", n_out - n0, sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    int w;
    pulse_clear();
    for (int i = 0; i < 8; i++) drive_beat(rand256(), (i == 7) ? 32'h0000_FFFF : 32'hFFFF_FFFF, i == 7, w);
    idle();
    settle(2);
    @(negedge clk);
    checks++;
    if (sm_byte_cnt !== 8'hF0 || byte_cnt !== 32'd240) begin
      errors++;
      $display("FAIL wrap_preset: got small=%h wide=%0d, required small=f0 wide=240", sm_byte_cnt, byte_cnt);
    end
    @(posedge clk); #1;
    drive_beat(rand256(), 32'hFFFF_FFFF, 1'b1, w);
    idle();
    @(negedge clk);
    checks++;
    if (sm_byte_cnt !== 8'h10 || byte_cnt !== 32'h110) begin
      errors++;
      $display("FAIL wrap: got small=%h wide=%h, required small=10 wide=110", sm_byte_cnt, byte_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_clear();
    int w;
    drop_en = 1'b1;
    drive_beat(rand256(), 32'hFFFF_FFFF, 1'b1, w);
    drop_en = 1'b0;
    drive_beat(rand256(), 32'hFFFF_FFFF, 1'b0, w);
    clear_stats = 1'b1;
    drive_beat(rand256(), 32'hFFFF_FFFF, 1'b1, w);
    clear_stats = 1'b0;
    idle();
    @(negedge clk);
    checks++;
    if (pkt_cnt !== '0 || drop_cnt !== '0 || byte_cnt !== '0) begin
      errors++;
      $display("FAIL clear: got pkt=%0d drop=%0d byte=%0d, required 0 0 0", pkt_cnt, drop_cnt, byte_cnt);
    end
    settle(3);
  endtask

  task automatic test_reset_mid();
    int w, n0;
    m_axis_tready = 1'b0;
    drive_beat(rand256(), 32'hFFFF_FFFF, 1'b0, w);
    drive_beat(rand256(), 32'hFFFF_FFFF, 1'b0, w);
    #2 areset = 1'b1;
    idle();
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tstrb !== '0 ||
        pkt_cnt !== '0 || byte_cnt !== '0 || in_pkt !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got tready=%0b tvalid=%0b strb=%h pkt=%0d byte=%0d in_pkt=%0b, required all 0",
               s_axis_tready, m_axis_tvalid, m_axis_tstrb, pkt_cnt, byte_cnt, in_pkt);
    end
    @(posedge clk); #2;
    areset = 1'b0;
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_ready0: got %0b, required 0", s_axis_tready);
    end
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ready1: got %0b, required 1", s_axis_tready);
    end
    @(posedge clk); #1;
    m_axis_tready = 1'b1;
    n0 = n_out;
    drive_beat(rand256(), 32'h0000_00FF, 1'b1, w);
    idle();
    settle(2);
    @(negedge clk);
    checks++;
    if (n_out - n0 !== 1 || pkt_cnt !== 32'd1 || byte_cnt !== 32'd8 || in_pkt !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_sop: got beats=%0d pkt=%0d byte=%0d in_pkt=%0b, required 1 1 8 0",
               n_out - n0, pkt_cnt, byte_cnt, in_pkt);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pass();
    test_drop();
    test_drop_mid();
    test_back_to_back();
    test_wrap();
    test_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
